// File: rtl/fir_ctrl_pkg.sv
// Shared constants and state type for the FIR frame sequencer.
package fir_ctrl_pkg;

   // Tap count of the attached filter; must match the filter build (>= 2).
   localparam int N_TAPS     = 4;
   // Group delay used to centre the "same"-length output window.
   localparam int SAME_DELAY = (N_TAPS - 1) / 2;
   // Zero cycles needed to drain (or purge) the filter delay line.
   localparam int FLUSH_LEN  = N_TAPS - 1;
   // Width of the shared purge/flush down-counter.
   localparam int CNT_W      = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;

   typedef enum logic [1:0] {
      PURGE = 2'd0,
      IDLE  = 2'd1,
      RUN   = 2'd2,
      FLUSH = 2'd3
   } state_t;

endpackage

// File: rtl/fir_ctrl_counter.sv
// Loadable down-counter with zero flag; times both PURGE and FLUSH.
module fir_ctrl_counter #(
   parameter int               WIDTH   = 2,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] cnt,
   output logic             zero
);

   // Reset loads the purge length; decrement stops at zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= RST_VAL;
      else if (load)
         cnt <= load_val;
      else if (en && (cnt != '0))
         cnt <= cnt - WIDTH'(1);
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/fir_frame_ctrl.sv
// Frame sequencer for the free-running FIR: purge, feed, zero-tail flush,
// and valid/last tagging of the filter output.
module fir_frame_ctrl
   import fir_ctrl_pkg::*;
#(
   parameter int IN_WIDTH  = 16,
   parameter int OUT_WIDTH = 40,
   parameter int LEN_WIDTH = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 s_valid,
   output logic                 s_ready,
   input  logic [IN_WIDTH-1:0]  s_data,
   input  logic                 s_last,
   input  logic                 mode_same,
   output logic [IN_WIDTH-1:0]  fir_x,
   input  logic [OUT_WIDTH-1:0] fir_y,
   output logic                 m_valid,
   output logic [OUT_WIDTH-1:0] m_data,
   output logic                 m_last,
   output logic                 busy,
   output logic                 err_gap,
   input  logic                 err_clr
);

   localparam logic [CNT_W-1:0]     FL_LAST = CNT_W'(FLUSH_LEN - 1);
   localparam logic [LEN_WIDTH:0]   D_X     = (LEN_WIDTH+1)'(SAME_DELAY);
   localparam logic [LEN_WIDTH-1:0] LEN_MAX =
      LEN_WIDTH'((longint'(1) << LEN_WIDTH) - longint'(N_TAPS));

   state_t               state, state_nxt;
   logic [LEN_WIDTH-1:0] len, len_nxt;
   logic [IN_WIDTH-1:0]  fx_nxt;
   logic                 mode_q, mode_nxt;
   logic                 err_set;
   logic                 cnt_load, cnt_en, cnt_zero;
   logic [CNT_W-1:0]     cnt;
   logic                 tag_vld, tag_lst;
   logic [2:1]           vld_pipe, lst_pipe;

   logic [CNT_W-1:0]     fl_j;
   logic [LEN_WIDTH:0]   len_x, k_fl, win_hi;
   logic                 len_sat;

   fir_ctrl_counter #(
      .WIDTH   (CNT_W),
      .RST_VAL (FL_LAST)
   ) u_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .en       (cnt_en),
      .load_val (FL_LAST),
      .cnt      (cnt),
      .zero     (cnt_zero)
   );

   // Output index during the tail is len + flush step; same-mode window ends at D+len-1.
   assign fl_j    = FL_LAST - cnt;
   assign len_x   = {1'b0, len};
   assign k_fl    = len_x + (LEN_WIDTH+1)'(fl_j);
   assign win_hi  = len_x + D_X - (LEN_WIDTH+1)'(1);
   assign len_sat = (len == LEN_MAX);

   // Next state, filter drive and tag for the beat launched at the next edge.
   always_comb begin
      state_nxt = state;
      s_ready   = 1'b0;
      fx_nxt    = '0;
      len_nxt   = len;
      mode_nxt  = mode_q;
      err_set   = 1'b0;
      cnt_load  = 1'b0;
      cnt_en    = 1'b0;
      tag_vld   = 1'b0;
      tag_lst   = 1'b0;
      case (state)
         PURGE: begin
            cnt_en = 1'b1;
            if (cnt_zero) state_nxt = IDLE;
         end
         IDLE: begin
            s_ready = 1'b1;
            if (s_valid) begin
               fx_nxt   = s_data;
               mode_nxt = mode_same;
               len_nxt  = LEN_WIDTH'(1);
               // entry beat is output index 0
               tag_vld  = !mode_same || (D_X == '0);
               tag_lst  = s_last && mode_same && (D_X == '0);
               if (s_last) begin
                  state_nxt = FLUSH;
                  cnt_load  = 1'b1;
               end else begin
                  state_nxt = RUN;
               end
            end
         end
         RUN: begin
            s_ready = 1'b1;
            // a missing sample is fed as zero and still counts toward the frame
            fx_nxt  = s_valid ? s_data : '0;
            err_set = !s_valid || len_sat;
            if (!len_sat) len_nxt = len + LEN_WIDTH'(1);
            tag_vld = !mode_q || (len_x >= D_X);
            tag_lst = s_valid && s_last && mode_q && (D_X == '0);
            if (s_valid && s_last) begin
               state_nxt = FLUSH;
               cnt_load  = 1'b1;
            end
         end
         FLUSH: begin
            cnt_en  = 1'b1;
            tag_vld = !mode_q || ((k_fl >= D_X) && (k_fl <= win_hi));
            tag_lst = mode_q ? (k_fl == win_hi) : cnt_zero;
            if (cnt_zero) state_nxt = IDLE;
         end
         default: state_nxt = PURGE;
      endcase
   end

   // Control state, filter drive register and frame bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= PURGE;
         fir_x  <= '0;
         len    <= '0;
         mode_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         fir_x  <= fx_nxt;
         len    <= len_nxt;
         mode_q <= mode_nxt;
      end
   end

   // Sticky gap/overflow flag; a new set wins over a clear.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         err_gap <= 1'b0;
      else
         err_gap <= err_set | (err_gap & ~err_clr);
   end

   // Two-stage tag pipe: stage 1 rides with fir_x, stage 2 lines up with fir_y.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_pipe <= '0;
         lst_pipe <= '0;
      end else begin
         vld_pipe <= {vld_pipe[1], tag_vld};
         lst_pipe <= {lst_pipe[1], tag_lst};
      end
   end

   assign m_valid = vld_pipe[2];
   assign m_last  = lst_pipe[2];
   assign m_data  = fir_y;
   assign busy    = (state != IDLE);

endmodule
